// File: rtl/gf_mul_pkg.sv
// Shared constants and FSM encoding for the GF(2^12) multiplier and
// reduction stages.
package gf_mul_pkg;

  localparam int N = 12;

  // f(x) = x^12 + x^3 + 1
  localparam logic [N:0] POLY = 13'h1009;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REDUCE = 2'd1,
    DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/gf_reduce_step.sv
// One reduction step: clears bit k of acc by XOR-ing in f(x) aligned to k,
// when that bit is set. Purely combinational.
module gf_reduce_step #(
  parameter int         N    = gf_mul_pkg::N,
  parameter logic [N:0] POLY = gf_mul_pkg::POLY,
  parameter int         KW   = $clog2(2*N-1)
) (
  input  logic [2*N-2:0] acc,
  input  logic [KW-1:0]  k,
  output logic [2*N-2:0] next
);

  localparam logic [2*N-2:0] POLY_EXT = {{(N-2){1'b0}}, POLY};

  // NOTE: next gets its default before the conditional update, so every
  // path assigns it and no latch is inferred.
  always_comb begin
    next = acc;
    if (int'(k) >= N && int'(k) <= 2*N-2 && acc[k]) begin
      next = acc ^ (POLY_EXT << (int'(k) - N));
    end
  end

endmodule

// File: rtl/gf2m_reduce_seq.sv
// Bit-serial reduction of a 2N-1 bit carry-less product modulo f(x), with
// valid/ready handshakes on both sides and fixed N+1 cycle initiation interval.
module gf2m_reduce_seq
  import gf_mul_pkg::*;
#(
  parameter int         N    = gf_mul_pkg::N,
  parameter logic [N:0] POLY = gf_mul_pkg::POLY
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*N-2:0] prod,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N-1:0]   r,
  output logic           busy
);

  localparam int KW = $clog2(2*N-1);

  state_t           state_q, state_d;
  logic [2*N-2:0]   acc_q;
  logic [2*N-2:0]   acc_step;
  logic [KW-1:0]    k_q;
  logic [N-1:0]     r_q;
  logic             out_valid_q;
  logic             last_step;

  gf_reduce_step #(
    .N    (N),
    .POLY (POLY),
    .KW   (KW)
  ) u_step (
    .acc  (acc_q),
    .k    (k_q),
    .next (acc_step)
  );

  assign last_step = (k_q == KW'(N));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid)  state_d = REDUCE;
      REDUCE:  if (last_step) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      k_q         <= '0;
      r_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            acc_q <= prod;
            k_q   <= KW'(2*N-2);
          end
        end
        REDUCE: begin
          acc_q <= acc_step;
          // k parks at N on the final step so it never leaves N..2N-2
          if (last_step) begin
            r_q         <= acc_step[N-1:0];
            out_valid_q <= 1'b1;
          end else begin
            k_q <= k_q - 1'b1;
          end
        end
        DONE: begin
          if (out_ready) out_valid_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign r         = r_q;

endmodule

// File: tb/tb_gf2m_reduce_seq.sv
// Self-checking bench for gf2m_reduce_seq: directed cases, backpressure,
// mid-operation reset and a randomized regression against a polynomial model.
module tb_gf2m_reduce_seq;

  localparam int LAT = 12;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [22:0] prod = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [11:0] r;
  logic        busy;

  int errors = 0;
  int checks = 0;

  gf2m_reduce_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .prod      (prod),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .r         (r),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [22:0] clmul(input logic [11:0] a, input logic [11:0] b);
    logic [22:0] y = '0;
    for (int i = 0; i < 12; i++)
      if (b[i]) y ^= 23'(a) << i;
    return y;
  endfunction

  // Residue as a sum of x^i mod f over the set bits of p.
  function automatic logic [11:0] ref_mod(input logic [22:0] p);
    logic [12:0] pw = 13'h001;
    logic [11:0] res = '0;
    for (int i = 0; i < 23; i++) begin
      if (p[i]) res ^= pw[11:0];
      pw = pw << 1;
      if (pw[12]) pw ^= 13'h1009;
    end
    return res;
  endfunction

  // Transaction-level model: result due LAT cycles after the accept cycle,
  // held until taken.
  bit          m_idle = 1'b1;
  int          cyc = 0;
  int          acc_cyc = 0;
  int          n_acc = 0;
  logic [11:0] exp_q[$];

  always @(posedge clk) begin
    if (rst) begin
      m_idle = 1'b1;
      exp_q.delete();
    end else if (m_idle) begin
      if (in_valid) begin
        m_idle  = 1'b0;
        acc_cyc = cyc;
        exp_q.push_back(ref_mod(prod));
        n_acc++;
      end
    end else if (cyc - acc_cyc >= LAT && out_ready) begin
      m_idle = 1'b1;
      void'(exp_q.pop_front());
    end
    cyc++;
  end

  always @(negedge clk) begin
    bit exp_valid;
    if (rst) begin
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_r", 32'(r), 32'd0);
    end else begin
      exp_valid = !m_idle && (cyc - acc_cyc >= LAT);
      check("in_ready", 32'(in_ready), 32'(m_idle));
      check("busy", 32'(busy), 32'(!m_idle));
      check("out_valid", 32'(out_valid), 32'(exp_valid));
      if (exp_valid && out_valid && exp_q.size() > 0) begin
        check("r", 32'(r), 32'(exp_q[0]));
        check("acc_upper_zero", 32'(dut.acc_q[22:12]), 32'd0);
      end
    end
  end

  // Called at a negedge; returns at the negedge of the first REDUCE cycle.
  task automatic accept(input logic [22:0] p);
    int n = 0;
    prod     = p;
    in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("accept_timeout", 32'(n < 100), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    prod     = 23'($urandom);
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    int lat;
    int base;
    int guard;
    logic [11:0] a;
    logic [11:0] b;

    check("model_x12", 32'(ref_mod(23'h001000)), 32'h009);
    check("model_x22", 32'(ref_mod(23'h400000)), 32'h412);
    check("model_small", 32'(ref_mod(23'h000ABC)), 32'hABC);
    check("model_clmul", 32'(clmul(12'h800, 12'h800)), 32'h400000);

    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("idle_in_ready", 32'(in_ready), 32'd1);

    accept(23'h001000);
    wait_valid(lat);
    check("lat_x12", 32'(lat), 32'(LAT));
    check("r_x12", 32'(r), 32'h009);
    release_result();

    accept(23'h400000);
    wait_valid(lat);
    check("lat_x22", 32'(lat), 32'(LAT));
    check("r_x22", 32'(r), 32'h412);
    release_result();

    // Backpressure with a second product already waiting
    accept(23'h000ABC);
    wait_valid(lat);
    check("lat_small", 32'(lat), 32'(LAT));
    check("r_small", 32'(r), 32'hABC);
    prod     = 23'h001000;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_r", 32'(r), 32'hABC);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_back_idle", 32'(in_ready), 32'd1);
    check("bp_out_valid_low", 32'(out_valid), 32'd0);
    accept(23'h001000);
    wait_valid(lat);
    check("lat_second", 32'(lat), 32'(LAT));
    check("r_second", 32'(r), 32'h009);
    release_result();

    // Reset in REDUCE cycle 6
    accept(23'h400000);
    repeat (5) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_r", 32'(r), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    accept(23'h001000);
    wait_valid(lat);
    check("lat_after_rst", 32'(lat), 32'(LAT));
    check("r_after_rst", 32'(r), 32'h009);
    release_result();

    // Random regression with random handshakes
    base  = n_acc;
    guard = 0;
    while ((n_acc - base < 1000 || !m_idle) && guard < 60000) begin
      a         = 12'($urandom);
      b         = 12'($urandom);
      prod      = clmul(a, b);
      in_valid  = (n_acc - base < 1000) && ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 1) == 1);
      @(negedge clk);
      guard++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("random_timeout", 32'(guard < 60000), 32'd1);
    check("random_count", 32'(n_acc - base), 32'd1000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gf2m_reduce_seq.md
# gf2m_reduce_seq

Sequential modular-reduction stage that sits directly downstream of the 12-bit overlap-free Karatsuba multiplier. It accepts the 23-bit carry-less product over GF(2), reduces it modulo a fixed irreducible polynomial of degree N, and returns the N-bit field element. Products enter and results leave through valid/ready handshakes. Reduction runs one bit per cycle, so latency is fixed and independent of the data.

## Interface
- N, default 12: field degree; the product input is 2N-1 bits wide.
- POLY, default 13'h1009: irreducible polynomial f(x) as N+1 bits, here x^12 + x^3 + 1. Bit N and bit 0 must both be 1.

- clk  in  1  Single clock; all state is updated on the rising edge.
- rst  in  1  Asynchronous, active-high reset.
- in_valid  in  1  The value on prod is valid.
- in_ready  out  1  Block can accept a product; high only in IDLE.
- prod  in  2N-1  Carry-less product from the multiplier (y of OKA_12bit).
- out_valid  out  1  The value on r is valid.
- out_ready  in  1  Consumer accepts r.
- r  out  N  Reduced result, prod mod f(x).
- busy  out  1  High in REDUCE or DONE.

## Operation
- Internal state:
  - acc[2N-2:0] holds the partial remainder.
  - k is a bit pointer with range N..2N-2.
  - FSM states are IDLE, REDUCE and DONE.
- IDLE:
  - in_ready=1.
  - On in_valid, load acc<=prod and k<=2N-2, then go to REDUCE.
- REDUCE:
  - Each cycle, if acc[k]=1 then acc <= acc ^ (POLY << (k-N)). Otherwise acc is unchanged.
  - Then k<=k-1.
  - When k==N, apply the step and go to DONE.
  - This gives exactly N-1 steps, with no early exit even when the upper bits are zero.
- DONE:
  - out_valid=1 and r=acc[N-1:0].
  - On out_ready, go to IDLE.
  - With out_ready low, hold indefinitely with r stable.
- Only GF(2) arithmetic is used (XOR, no carries). acc[2N-2:N] must be zero on entry to DONE; the bench checks this as an assertion.
- in_valid while not in IDLE is ignored; prod is not sampled.
- A product that is already below x^N still takes the full latency, and r equals prod[N-1:0].

## Timing
- Reset values: state=IDLE, acc=0, k=0, in_ready=1, out_valid=0, r=0, busy=0.
- An asserted rst mid-operation aborts the reduction. The partial result is discarded, and the block is back in IDLE on the first edge after rst falls.
- Handshake sequence:
  - Accept edge at cycle 0.
  - REDUCE in cycles 1..N-1 (11 cycles for N=12).
  - out_valid high from cycle N (12).
- Minimum initiation interval is N+1 cycles (13): accept cycle, N-1 reduce cycles, one DONE cycle with out_ready=1.
- in_ready is deasserted in DONE even when out_ready=1 in the same cycle. There is no overlap between consecutive operations.
- r and out_valid are registered. They stay stable while out_valid=1 and out_ready=0.

## Structure
- Shared package gf_mul_pkg holds:
  - the constant N;
  - the constant POLY;
  - the FSM state enum (IDLE, REDUCE, DONE).
  The multiplier, this block and later field stages all import it.
- One combinational sub-module, gf_reduce_step. It takes acc and k and returns the conditionally XOR-shifted acc. This isolates the datapath for unit checking.
- Top-level integration: OKA_12bit y drives prod directly. Operand registers for OKA_12bit live upstream and are not part of this block.

## Test plan
- prod=23'h001000 (x^12) -> r=12'h009, with out_valid exactly 12 cycles after the accept edge.
- prod=23'h400000 (x^22, i.e. a=b=12'h800 through OKA_12bit) -> r=12'h412.
- prod=23'h000ABC -> r=12'hABC after the full 12-cycle latency, with no early completion.
- Backpressure:
  - Hold out_ready=0 for 5 cycles in DONE -> r and out_valid stay stable and in_ready stays 0.
  - Then out_ready=1 -> IDLE on the next edge.
  - A second product that was held with in_valid during DONE is accepted only after that.
- Assert rst at cycle 6 of REDUCE -> immediately out_valid=0, r=0 and in_ready=1. After rst falls, a new prod=23'h001000 completes normally with r=12'h009.
- Random regression:
  - Run 1000 random a,b pairs through OKA_12bit into this block.
  - Compare r against a software carry-less multiply-mod-f.
  - Check the upper acc bits are zero in DONE.
  - Drive in_valid and out_ready randomly throughout.
